// File: rtl/stream_seq_ctrl.sv
// stream_seq_ctrl
//   Sequences read-out of the bundled sign-bit hypervector to the output
//   AXI-Stream port. After the final store (last_in), the block waits LAT
//   cycles for the counter pipeline to settle. It then issues one 32-bit word
//   index per beat on stream_v/stream_i and tracks the dst_valid/dst_last
//   handshake under dst_ready back-pressure.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-low reset
//   start      in   pulse: arm for a new job (honoured only when idle)
//   last_in    in   pulse: final store of the job issued to the counters
//   dst_ready  in   downstream AXI-Stream ready
//   stream_v   out  combinational: buffer loads word stream_i at this edge
//   stream_i   out  index of the word being loaded
//   dst_valid  out  registered: stream_d holds a word not yet accepted
//   dst_last   out  registered: current beat is word WORDS-1
//   busy       out  registered: controller not idle
//   done       out  registered: one-cycle pulse after final beat accepted
module stream_seq_ctrl #(
    parameter int DIM   = 1023,
    parameter int WORDS = (DIM + 1) / 32,
    parameter int IW    = 6,
    parameter int LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          last_in,
    input  logic          dst_ready,
    output logic          stream_v,
    output logic [IW-1:0] stream_i,
    output logic          dst_valid,
    output logic          dst_last,
    output logic          busy,
    output logic          done
);

    localparam int            CW          = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IW:0]   WORDS_C     = (IW + 1)'(WORDS);
    localparam logic [IW:0]   LAST_C      = (IW + 1)'(WORDS - 1);
    localparam logic [CW-1:0] SETTLE_INIT = CW'((LAT > 0) ? LAT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SETTLE,
        STREAM
    } state_t;

    // With no settle latency the counters are already valid, so skip SETTLE.
    localparam state_t AFTER_LAST = (LAT == 0) ? STREAM : SETTLE;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // One bit wider than stream_i so the issue count can saturate at WORDS
    // even when WORDS == 2**IW.
    logic [IW:0]   issued_q, issued_d;
    logic          dst_valid_q, dst_valid_d;
    logic          dst_last_q, dst_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          stream_v_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issued_d    = issued_q;
        dst_valid_d = dst_valid_q;
        dst_last_d  = dst_last_q;
        done_d      = 1'b0;

        // At most one word in flight: load only when the output register is
        // empty or is being drained at this edge.
        stream_v_c = (state_q == STREAM) && (issued_q < WORDS_C) &&
                     (!dst_valid_q || dst_ready);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (last_in) begin
                        state_d = AFTER_LAST;
                        cnt_d   = SETTLE_INIT;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (last_in) begin
                    state_d = AFTER_LAST;
                    cnt_d   = SETTLE_INIT;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STREAM: begin
                if (stream_v_c) begin
                    dst_valid_d = 1'b1;
                    dst_last_d  = (issued_q == LAST_C);
                    issued_d    = issued_q + (IW + 1)'(1);
                end else if (dst_valid_q && dst_ready) begin
                    dst_valid_d = 1'b0;
                    dst_last_d  = 1'b0;
                    // The last word has already been issued, so stream_v_c
                    // cannot coincide with the final handshake.
                    if (dst_last_q) begin
                        state_d  = IDLE;
                        issued_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            issued_q    <= '0;
            dst_valid_q <= 1'b0;
            dst_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            issued_q    <= issued_d;
            dst_valid_q <= dst_valid_d;
            dst_last_q  <= dst_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stream_v  = stream_v_c;
    assign stream_i  = issued_q[IW-1:0];
    assign dst_valid = dst_valid_q;
    assign dst_last  = dst_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
